// File: rtl/byte_asm_pkg.sv
// Shared widths, FSM state encoding and parity helper for byte_assembler.
// The PAR state exists only when BYTE_ASM_PARITY_EN is defined.
package byte_asm_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef BYTE_ASM_PARITY_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    // High when the 8 data bits plus parity bit hold an odd number of ones.
    function automatic logic parity_bad(input logic [BYTE_W-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// 8-bit serial-in/parallel-out register; pdata is the value the register
// takes at the coming edge (shifted when shift_en, otherwise held).
module sipo_shift
    import byte_asm_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              shift_en,
    input  logic              clear,
    output logic [BYTE_W-1:0] pdata
);

    logic [BYTE_W-1:0] q;

    always_comb begin
        if (!shift_en)
            pdata = q;
        else if (MSB_FIRST != 0)
            pdata = {q[BYTE_W-2:0], din};
        else
            pdata = {din, q[BYTE_W-1:1]};
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clear)
            q <= '0;
        else
            q <= pdata;
    end

endmodule

// File: rtl/byte_assembler.sv
// Serial-to-byte assembler feeding a popcount stage (a/load).
// Optional even-parity frame bit and par_err port under BYTE_ASM_PARITY_EN.
module byte_assembler
    import byte_asm_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              sin_clear,
    output logic [BYTE_W-1:0] a,
    output logic              load,
    output logic              busy,
    output logic [7:0]        byte_cnt
`ifdef BYTE_ASM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              data_bit, last_bit, done;
    logic [BYTE_W-1:0] pdata;

    sipo_shift #(.MSB_FIRST(MSB_FIRST)) u_sipo (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (sin),
        .shift_en (data_bit),
        .clear    (sin_clear),
        .pdata    (pdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (sin_clear) begin
            state_nxt = IDLE;
        end else if (sin_valid) begin
            case (state)
                IDLE:    state_nxt = SHIFT;
`ifdef BYTE_ASM_PARITY_EN
                SHIFT:   if (last_bit) state_nxt = PAR;
                PAR:     state_nxt = IDLE;
`else
                SHIFT:   if (last_bit) state_nxt = IDLE;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
`ifdef BYTE_ASM_PARITY_EN
        data_bit = sin_valid && (state != PAR);
        last_bit = data_bit && (bit_cnt == CNT_W'(BYTE_W - 1));
        done     = sin_valid && !sin_clear && (state == PAR);
`else
        data_bit = sin_valid;
        last_bit = data_bit && (bit_cnt == CNT_W'(BYTE_W - 1));
        done     = last_bit && !sin_clear;
`endif
    end

    // Wraps 7 -> 0 on the last data bit, ready for the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (sin_clear)
            bit_cnt <= '0;
        else if (data_bit)
            bit_cnt <= bit_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            load     <= 1'b0;
            byte_cnt <= 8'h00;
        end else begin
            load <= done;
            if (done) begin
                a        <= pdata;
                byte_cnt <= byte_cnt + 8'd1;
            end
        end
    end

`ifdef BYTE_ASM_PARITY_EN
    // In PAR the register holds, so pdata is the data byte and sin the parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err <= 1'b0;
        else if (done)
            par_err <= parity_bad(pdata, sin);
    end
`endif

endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in a[7]; 0 = first received bit lands in a[0].
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sin  input  1  serial data bit.
REQ-005 SHALL have port sin_valid  input  1  sin sampled on this edge when high.
REQ-006 SHALL have port sin_clear  input  1  synchronous abort of the partial byte.
REQ-007 SHALL have port a  output  8  last completed byte, registered; feeds the popcount stage's a input.
REQ-008 SHALL have port load  output  1  one-cycle pulse, a newly valid; feeds the popcount stage's load input.
REQ-009 SHALL have port busy  output  1  high while a partial byte is held (bit count 1..7, or the parity wait).
REQ-010 SHALL have port byte_cnt  output  8  count of completed bytes, wraps 255->0.
REQ-011 SHALL have port par_err  output  1  parity-error flag; present only under BYTE_ASM_PARITY_EN.

Function
REQ-012 SHALL implement FSM states IDLE (0 bits held), SHIFT (1..7 bits held) and PAR (8 data bits held, awaiting parity; only when BYTE_ASM_PARITY_EN is defined).
- IDLE + sin_valid -> SHIFT.
- SHIFT + sin_valid on the 8th bit -> IDLE, or -> PAR when parity is compiled in.
- PAR + sin_valid -> IDLE.
REQ-013 SHALL use a 3-bit bit counter that increments only on an accepted bit; no stalls, since every sin_valid cycle is accepted.
REQ-014 SHALL, on byte completion, update a and pulse load high for exactly one cycle in the cycle after the completing edge; a SHALL then hold until the next completion.
REQ-015 SHALL increment byte_cnt at the same edge that sets load, wrapping 8'hFF -> 8'h00.
REQ-016 SHALL accept a sin_valid that coincides with a load pulse as bit 0 of the next byte, giving back-to-back bytes with no bubble.
REQ-017 SHALL, on sin_clear, return to IDLE with bit count 0 and discard the partial byte.
- sin_clear with sin_valid: clear wins, bit discarded.
- sin_clear on the completing edge: clear wins, no load, a unchanged, byte_cnt unchanged.
REQ-018 SHALL leave a, byte_cnt and par_err unaffected by sin_clear.
REQ-019 SHALL drive busy combinationally from the state (busy = state != IDLE).
REQ-020 SHALL ignore sin whenever sin_valid is low.

Reset
REQ-021 SHALL, on rst_n low at any time, asynchronously force the outputs and internal state as follows:
- state = IDLE, bit count = 0, shift register = 8'h00;
- a = 8'h00, load = 0, byte_cnt = 8'h00, par_err = 0.
REQ-022 SHALL discard any partial byte when reset occurs mid-byte; first byte after rst_n release starts at bit 0.

Configuration
REQ-023 SHALL use macro BYTE_ASM_PARITY_EN.
- Defined: a 9th bit is expected after the 8 data bits, even parity over 9 bits. load and a update only after the parity bit is accepted. par_err is set on a mismatch and cleared on the next good byte. The byte is still delivered on a mismatch.
- Undefined: no PAR state, no par_err port, 8-bit frames.

Structure
REQ-024 SHALL place BYTE_W=8, CNT_W=3 and the FSM state enum in shared package byte_asm_pkg.
REQ-025 SHALL use one sub-module sipo_shift: 8-bit serial-in/parallel-out register with parameter MSB_FIRST, shift enable and synchronous clear.

Verification
REQ-026 MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> load pulses one cycle after the 8th bit, a=8'hB2, byte_cnt=1; the downstream popcount stage then sees 4.
REQ-027 MSB_FIRST=0, same bit stream -> a=8'h4D.
REQ-028 Two bytes 8'hFF then 8'h01 back-to-back with no gaps -> two load pulses 8 cycles apart, a=8'hFF then 8'h01, byte_cnt=2.
REQ-029 Five bits sent, then sin_clear, then 8'h0F -> single load, a=8'h0F, busy low after the clear cycle.
REQ-030 rst_n low after 3 bits of a byte, then release and send 8'hA5 -> a=8'hA5, byte_cnt=1, no spurious load during reset.
REQ-031 With BYTE_ASM_PARITY_EN: send 8'h03 with parity bit 0 -> par_err=0; send 8'h07 with parity bit 0 -> par_err=1, a=8'h07; byte_cnt wraps to 0 after 256 bytes.
